cast_stream: RTL

- Parametrised, registered, flow-controlled width cast between IN_W-bit and OUT_W-bit streams.
- Generalises the fixed 4/8-bit zero-extend/truncate cast:
  - Any widths.
  - Runtime signed/unsigned mode.
  - Wrap or saturate narrowing.
  - Per-beat overflow flag.
  - Valid/ready handshake through a 2-entry skid buffer.
- Sits between datapath stages of different widths, e.g. accumulator to narrower bus, or narrow sample to wide ALU.

---
 rtl/cast_pkg.sv | 19 +
 rtl/skid_buf.sv | 71 +++++++
 rtl/cast_stream.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cast_pkg.sv
// Shared types for the width-cast stream: cast mode encoding and mode decode helpers.
package cast_pkg;

   typedef enum logic [1:0] {
      CAST_ZERO = 2'd0,
      CAST_SIGN = 2'd1,
      CAST_USAT = 2'd2,
      CAST_SSAT = 2'd3
   } cast_mode_e;

   function automatic logic mode_is_signed(input cast_mode_e m);
      return (m == CAST_SIGN) || (m == CAST_SSAT);
   endfunction

   function automatic logic mode_is_sat(input cast_mode_e m);
      return (m == CAST_USAT) || (m == CAST_SSAT);
   endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-entry valid/ready skid buffer; in_ready is registered, outputs come only from the main entry.
module skid_buf #(
   parameter int DATA_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   logic              main_valid_q, main_valid_d;
   logic [DATA_W-1:0] main_data_q,  main_data_d;
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] skid_data_q,  skid_data_d;
   logic              in_ready_q,   in_ready_d;
   logic              accept_s, emit_s;

   // Next-state: refill main from skid first so beat order is preserved
   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      accept_s     = in_valid & in_ready_q;
      emit_s       = main_valid_q & out_ready;
      if (emit_s || !main_valid_q) begin
         if (skid_valid_q) begin
            main_valid_d = 1'b1;
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
         end else if (accept_s) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (accept_s) begin
         skid_valid_d = 1'b1;
         skid_data_d  = in_data;
      end else begin
         skid_valid_d = skid_valid_q;
      end
      in_ready_d = ~skid_valid_d;
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_q <= 1'b0;
         main_data_q  <= {DATA_W{1'b0}};
         skid_valid_q <= 1'b0;
         skid_data_q  <= {DATA_W{1'b0}};
         in_ready_q   <= 1'b1;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = main_valid_q;
   assign out_data  = main_data_q;

endmodule

// File: rtl/cast_stream.sv
// Registered IN_W -> OUT_W width cast with wrap/saturate modes, overflow flag and skid buffering.
// Optional saturation event counter port sat_cnt is enabled by defining CAST_STREAM_SAT_CNT_EN.
module cast_stream
   import cast_pkg::*;
#(
   parameter int IN_W      = 8,
   parameter int OUT_W     = 4,
   parameter int SAT_CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  cast_mode_e       mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_ovf,
   output logic             ovf_sticky,
   input  logic             ovf_clr
`ifdef CAST_STREAM_SAT_CNT_EN
   ,
   output logic [SAT_CNT_W-1:0] sat_cnt
`endif
);

   localparam int EW = IN_W + OUT_W;
`ifdef CAST_STREAM_SAT_CNT_EN
   localparam int BUF_W = OUT_W + 2;
`else
   localparam int BUF_W = OUT_W + 1;
`endif

   // Extending by OUT_W bits makes the dropped-bit range non-empty for any width pair,
   // so widening and equal widths fall out naturally with ovf = 0.
   function automatic logic [OUT_W:0] cast_fn(input logic [IN_W-1:0] din, input cast_mode_e m);
      logic [EW-1:0]    ext_z;
      logic [EW-1:0]    ext_s;
      logic [OUT_W-1:0] smax;
      logic             uovf;
      logic             sovf;
      ext_z = {{OUT_W{1'b0}}, din};
      ext_s = {{OUT_W{din[IN_W-1]}}, din};
      uovf  = |ext_z[EW-1:OUT_W];
      sovf  = ~((&ext_s[EW-1:OUT_W-1]) | ~(|ext_s[EW-1:OUT_W-1]));
      smax  = {OUT_W{1'b1}} >> 1;
      case (m)
         CAST_ZERO: cast_fn = {uovf, ext_z[OUT_W-1:0]};
         CAST_SIGN: cast_fn = {sovf, ext_s[OUT_W-1:0]};
         CAST_USAT: cast_fn = uovf ? {1'b1, {OUT_W{1'b1}}} : {1'b0, ext_z[OUT_W-1:0]};
         CAST_SSAT: cast_fn = sovf ? {1'b1, (din[IN_W-1] ? ~smax : smax)} : {1'b0, ext_s[OUT_W-1:0]};
         default:   cast_fn = {uovf, ext_z[OUT_W-1:0]};
      endcase
   endfunction

   logic [BUF_W-1:0] buf_in_s;
   logic [BUF_W-1:0] buf_out_s;
   logic             emit_ovf_s;
   logic             ovf_sticky_q, ovf_sticky_d;

`ifdef CAST_STREAM_SAT_CNT_EN
   assign buf_in_s = {mode_is_sat(mode), cast_fn(in_data, mode)};
`else
   assign buf_in_s = cast_fn(in_data, mode);
`endif

   skid_buf #(.DATA_W(BUF_W)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (buf_in_s),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (buf_out_s)
   );

   assign out_data   = buf_out_s[OUT_W-1:0];
   assign out_ovf    = buf_out_s[OUT_W];
   assign emit_ovf_s = out_valid & out_ready & buf_out_s[OUT_W];

   // Sticky overflow: clear wins over a same-cycle set
   always_comb begin
      if (ovf_clr) begin
         ovf_sticky_d = 1'b0;
      end else begin
         ovf_sticky_d = ovf_sticky_q | emit_ovf_s;
      end
   end

   // Sticky overflow register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_sticky_q <= 1'b0;
      end else begin
         ovf_sticky_q <= ovf_sticky_d;
      end
   end

   assign ovf_sticky = ovf_sticky_q;

`ifdef CAST_STREAM_SAT_CNT_EN
   logic [SAT_CNT_W-1:0] sat_cnt_q, sat_cnt_d;

   // Saturating count of overflowed beats emitted in a clamping mode
   always_comb begin
      if (ovf_clr) begin
         sat_cnt_d = {SAT_CNT_W{1'b0}};
      end else if (emit_ovf_s && buf_out_s[OUT_W+1] && !(&sat_cnt_q)) begin
         sat_cnt_d = sat_cnt_q + {{(SAT_CNT_W-1){1'b0}}, 1'b1};
      end else begin
         sat_cnt_d = sat_cnt_q;
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_cnt_q <= {SAT_CNT_W{1'b0}};
      end else begin
         sat_cnt_q <= sat_cnt_d;
      end
   end

   assign sat_cnt = sat_cnt_q;
`endif

endmodule
